// File: rtl/trigger_unit.sv
// Per-cycle trigger detector: compares a probed bus against a programmable value and mask.
// It supports masked level-compare and masked rising-edge modes and gives a registered hit flag.
module trigger_unit #(
  parameter int PROBE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe_data,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [1:0]         trig_mode,
  output logic               trigger_hit
);

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_RISING = 2'd1,
    MODE_RSVD2  = 2'd2,
    MODE_RSVD3  = 2'd3
  } trig_mode_t;

  logic [PROBE_W-1:0] prev_probe_reg;
  logic               trigger_hit_reg;
  logic               trigger_hit_next;

  logic [PROBE_W-1:0] level_miss;
  logic [PROBE_W-1:0] masked_cur;
  logic [PROBE_W-1:0] masked_prev;
  logic               level_hit;
  logic               rise_hit;

  // The current mask qualifies both the live sample and the stored history.
  for (genvar gi = 0; gi < PROBE_W; gi++) begin : g_bit
    assign level_miss[gi]  = (probe_data[gi] ^ trig_value[gi]) & trig_mask[gi];
    assign masked_cur[gi]  = probe_data[gi] & trig_mask[gi];
    assign masked_prev[gi] = prev_probe_reg[gi] & trig_mask[gi];
  end

  assign level_hit = (level_miss == '0);
  assign rise_hit  = (masked_prev == '0) && (masked_cur != '0);

  always_comb begin
    trigger_hit_next = 1'b0;
    case (trig_mode_t'(trig_mode))
      MODE_LEVEL:  trigger_hit_next = level_hit;
      MODE_RISING: trigger_hit_next = rise_hit;
      default:     trigger_hit_next = 1'b0;
    endcase
  end

  // History is captured in every mode, so a mode switch sees the true previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_probe_reg  <= '0;
      trigger_hit_reg <= 1'b0;
    end else begin
      prev_probe_reg  <= probe_data;
      trigger_hit_reg <= trigger_hit_next;
    end
  end

  assign trigger_hit = trigger_hit_reg;

endmodule

// File: tb/tb_trigger_unit.sv
// Scoreboard bench for trigger_unit: a reference model predicts each hit,
// which is queued at drive time and compared one edge later.
module tb_trigger_unit;

  localparam int PROBE_W = 8;

  logic               clk;
  logic               rst;
  logic [PROBE_W-1:0] probe_data;
  logic [PROBE_W-1:0] trig_value;
  logic [PROBE_W-1:0] trig_mask;
  logic [1:0]         trig_mode;
  logic               trigger_hit;

  int checks = 0;
  int errors = 0;

  bit                 exp_q[$];
  string              tag_q[$];
  logic [PROBE_W-1:0] model_prev = '0;

  trigger_unit #(.PROBE_W(PROBE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .probe_data (probe_data),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .trig_mode  (trig_mode),
    .trigger_hit(trigger_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: trigger_hit=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one sample, predict the hit, then compare after the sampling edge.
  task automatic step(input string tag, input bit r, input logic [7:0] p,
                      input logic [7:0] v, input logic [7:0] m, input logic [1:0] md);
    bit exp;
    bit got_exp;
    string got_tag;
    @(negedge clk);
    rst = r; probe_data = p; trig_value = v; trig_mask = m; trig_mode = md;
    if (r) exp = 1'b0;
    else if (md == 2'd0) exp = (((p ^ v) & m) == 8'h00);
    else if (md == 2'd1) exp = ((model_prev & m) == 8'h00) && ((p & m) != 8'h00);
    else exp = 1'b0;
    model_prev = r ? 8'h00 : p;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
    end else begin
      got_exp = exp_q.pop_front();
      got_tag = tag_q.pop_front();
      check_val(got_tag, trigger_hit, got_exp);
      $display("txn %-10s rst=%0b mode=%0d mask=%02h value=%02h probe=%02h hit=%0b exp=%0b",
               got_tag, r, md, m, v, p, trigger_hit, got_exp);
    end
  endtask

  initial begin
    rst = 1'b1; probe_data = '0; trig_value = 8'h01; trig_mask = 8'hFF; trig_mode = 2'd0;

    step("reset0", 1, 8'h00, 8'h01, 8'hFF, 2'd0);
    step("reset1", 1, 8'h00, 8'h01, 8'hFF, 2'd0);
    for (int i = 0; i < 3; i++) step("idle", 0, 8'h00, 8'h01, 8'hFF, 2'd0);

    step("lvl_miss", 0, 8'h00, 8'hA5, 8'hFF, 2'd0);
    step("lvl_hit", 0, 8'hA5, 8'hA5, 8'hFF, 2'd0);
    step("lvl_hold", 0, 8'hA5, 8'hA5, 8'hFF, 2'd0);
    step("lvl_drop", 0, 8'hA4, 8'hA5, 8'hFF, 2'd0);

    step("lvlm_hit", 0, 8'hAF, 8'hA0, 8'hF0, 2'd0);
    step("lvlm_miss", 0, 8'hBF, 8'hA0, 8'hF0, 2'd0);
    step("lvl_mask0", 0, 8'h3C, 8'hC3, 8'h00, 2'd0);

    step("rise_00", 0, 8'h00, 8'h00, 8'h0F, 2'd1);
    step("rise_01", 0, 8'h01, 8'h00, 8'h0F, 2'd1);
    step("rise_03", 0, 8'h03, 8'h00, 8'h0F, 2'd1);
    step("rise_00b", 0, 8'h00, 8'h00, 8'h0F, 2'd1);
    step("rise_08", 0, 8'h08, 8'h00, 8'h0F, 2'd1);
    step("rise_mskd", 0, 8'hF0, 8'h00, 8'h0F, 2'd1);
    step("rise_m0", 0, 8'h00, 8'h00, 8'h00, 2'd1);
    step("rise_m0b", 0, 8'hFF, 8'h00, 8'h00, 2'd1);

    step("rsvd2", 0, 8'hFF, 8'hFF, 8'hFF, 2'd2);
    step("rsvd3", 0, 8'hFF, 8'h00, 8'h00, 2'd3);
    step("rsvd2b", 0, 8'hFF, 8'h00, 8'h00, 2'd2);
    step("rsvd3b", 0, 8'h00, 8'h00, 8'hFF, 2'd3);

    step("mid_lvl", 0, 8'h5A, 8'h5A, 8'hFF, 2'd0);
    step("mid_rst", 1, 8'h5A, 8'h5A, 8'hFF, 2'd0);
    step("post_rise", 0, 8'h01, 8'h00, 8'hFF, 2'd1);
    step("post_hold", 0, 8'h01, 8'h00, 8'hFF, 2'd1);

    // History stored under a reserved mode must feed a later RISING compare.
    step("hist_rsvd", 0, 8'h00, 8'h00, 8'hFF, 2'd2);
    step("hist_rise", 0, 8'h80, 8'h00, 8'hFF, 2'd1);

    for (int i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(0, 19) == 0),
           8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
